// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared types and Booth digit decode for booth_seq_mult
// Purpose: default operand width, FSM state enum, radix-4 Booth digit enum
//          and the triplet-to-digit decode function.
package booth_pkg;

    localparam int WIDTH_DEF = 12;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        PP_ZERO,
        PP_POS1,
        PP_POS2,
        PP_NEG1,
        PP_NEG2
    } pp_digit_e;

    // Radix-4 Booth recoding of {q[i+1], q[i], q[i-1]}.
    function automatic pp_digit_e booth_digit(input logic [2:0] trip);
        pp_digit_e d;
        case (trip)
            3'b001, 3'b010: d = PP_POS1;
            3'b011:         d = PP_POS2;
            3'b100:         d = PP_NEG2;
            3'b101, 3'b110: d = PP_NEG1;
            default:        d = PP_ZERO;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// rtl/booth_pp_sel.sv - radix-4 Booth partial product selector
// Purpose: combinational selection of 0, +/-M or +/-2M from a Booth triplet.
// Ports:
//   triplet  in   3        {Q[1], Q[0], q_-1}
//   m        in   WIDTH+2  sign-extended multiplicand
//   pp       out  WIDTH+2  signed partial product
module booth_pp_sel
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [2:0]              triplet,
    input  logic signed [WIDTH+1:0] m,
    output logic signed [WIDTH+1:0] pp
);

    logic signed [WIDTH+1:0] m2;

    // M carries two guard bits, so 2M (and -2M of the most negative M)
    // still fits without overflow.
    assign m2 = {m[WIDTH:0], 1'b0};

    always_comb begin
        pp = '0;
        case (booth_digit(triplet))
            PP_POS1: pp = m;
            PP_POS2: pp = m2;
            PP_NEG1: pp = -m;
            PP_NEG2: pp = -m2;
            default: pp = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_mult.sv
// rtl/booth_seq_mult.sv - sequential signed radix-4 Booth multiplier
// Purpose: latches two signed operands on en in IDLE, retires one Booth digit
//          per clock and presents a held 2*WIDTH-bit product with a pulse.
// Ports:
//   clk         in   1        system clock, rising edge
//   rst         in   1        asynchronous reset, active-high
//   en          in   1        start strobe, sampled only in IDLE
//   mult_1      in   WIDTH    signed multiplicand
//   mult_2      in   WIDTH    signed multiplier
//   busy        out  1        high in CALC and DONE
//   result      out  2*WIDTH  signed product, registered and held
//   result_rdy  out  1        one-cycle pulse when result updates
module booth_seq_mult
    import booth_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [WIDTH-1:0]   mult_1,
    input  logic [WIDTH-1:0]   mult_2,
    output logic               busy,
    output logic [2*WIDTH-1:0] result,
    output logic               result_rdy
);

    localparam int CNT_W = $clog2(WIDTH / 2 + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH / 2 - 1);

    state_e                  state_q, state_d;
    logic signed [WIDTH+1:0] m_q, m_d;
    logic signed [WIDTH+1:0] a_q, a_d;
    logic [WIDTH-1:0]        q_q, q_d;
    logic                    qm1_q, qm1_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]      result_q, result_d;
    logic                    rdy_q, rdy_d;

    logic signed [WIDTH+1:0] pp;
    logic signed [WIDTH+1:0] sum;

    booth_pp_sel #(.WIDTH(WIDTH)) u_pp_sel (
        .triplet ({q_q[1:0], qm1_q}),
        .m       (m_q),
        .pp      (pp)
    );

    assign sum = a_q + pp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            m_q      <= '0;
            a_q      <= '0;
            q_q      <= '0;
            qm1_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            m_q      <= m_d;
            a_q      <= a_d;
            q_q      <= q_d;
            qm1_q    <= qm1_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            rdy_q    <= rdy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        m_d      = m_q;
        a_d      = a_q;
        q_d      = q_q;
        qm1_d    = qm1_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        rdy_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    m_d     = {{2{mult_1[WIDTH-1]}}, mult_1};
                    q_d     = mult_2;
                    qm1_d   = 1'b0;
                    a_d     = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // Accumulate, then arithmetic-shift {A,Q,q_-1} right by two.
                a_d   = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
                q_d   = {sum[1:0], q_q[WIDTH-1:2]};
                qm1_d = q_q[1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // Load the product on entry to DONE so that result and
                    // result_rdy are both valid during the DONE cycle.
                    state_d  = DONE;
                    result_d = {a_d[WIDTH-1:0], q_d};
                    rdy_d    = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign result     = result_q;
    assign result_rdy = rdy_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb/tb_booth_seq_mult.sv - directed self-checking bench for booth_seq_mult
module tb_booth_seq_mult;

    logic        clk;
    logic        rst;
    logic        en;
    logic [11:0] mult_1;
    logic [11:0] mult_2;
    logic        busy;
    logic [23:0] result;
    logic        result_rdy;

    int total = 0;
    int bad   = 0;

    booth_seq_mult #(.WIDTH(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mult_1     (mult_1),
        .mult_2     (mult_2),
        .busy       (busy),
        .result     (result),
        .result_rdy (result_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive operands with en for one sampling edge; returns #1 after that edge.
    task automatic start(input logic [11:0] a, input logic [11:0] b);
        @(negedge clk);
        mult_1 = a;
        mult_2 = b;
        en     = 1'b1;
        @(posedge clk);
        #1 en = 1'b0;
    endtask

    // Observe ten cycles after the sampling edge. n counts negedges after it;
    // result_rdy must appear exactly at n=6 and busy for n=0..6.
    // poke_at >= 0 injects an en pulse with new operands while busy.
    task automatic watch(input logic [23:0] exp, input string tag, input int poke_at);
        int rdy_cnt  = 0;
        int rdy_at   = -1;
        int busy_cnt = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (n == poke_at) begin
                en     = 1'b1;
                mult_1 = 12'd7;
                mult_2 = 12'd7;
            end else begin
                en = 1'b0;
            end
            if (busy) busy_cnt++;
            if (result_rdy) begin
                rdy_cnt++;
                rdy_at = n;
                chk({tag, "_result"}, result, exp);
            end
        end
        chk({tag, "_rdy_count"}, rdy_cnt, 1);
        chk({tag, "_rdy_cycle"}, rdy_at, 6);
        chk({tag, "_busy_cycles"}, busy_cnt, 7);
        chk({tag, "_held"}, result, exp);
    endtask

    initial begin
        int bad_cycles;
        int rdy_pos[$];
        rst    = 1'b1;
        en     = 1'b0;
        mult_1 = '0;
        mult_2 = '0;
        repeat (3) @(negedge clk);
        chk("reset_result", result, 0);
        chk("reset_rdy", result_rdy, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bad_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (result !== 24'h0 || result_rdy !== 1'b0 || busy !== 1'b0) bad_cycles++;
        end
        chk("idle_quiet", bad_cycles, 0);

        start(12'd3, 12'd4);        watch(24'h00000C, "basic", -1);
        start(12'h800, 12'h800);    watch(24'h400000, "min_min", -1);
        start(12'h800, 12'h7FF);    watch(24'hC00800, "min_max", -1);
        start(12'h7FF, 12'h7FF);    watch(24'h3FF001, "max_max", -1);
        start(12'hFFF, 12'hFFF);    watch(24'h000001, "m1_m1", -1);
        start(12'd0, 12'hB2E);      watch(24'h000000, "zero", -1);
        start(12'd5, 12'd6);        watch(24'h00001E, "busy_prot", 2);

        // Back-to-back with en held high; second operands set while busy.
        @(negedge clk);
        mult_1 = 12'd1;
        mult_2 = 12'd1;
        en     = 1'b1;
        @(posedge clk);
        #1;
        mult_1 = 12'hFFD;
        mult_2 = 12'd5;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            if (result_rdy) begin
                rdy_pos.push_back(n);
                if (n == 6) chk("b2b_first", result, 24'h000001);
                if (n == 14) chk("b2b_second", result, 24'hFFFFF1);
            end
            if (n == 10) chk("b2b_hold", result, 24'h000001);
        end
        en = 1'b0;
        chk("b2b_pulses", rdy_pos.size(), 2);
        if (rdy_pos.size() == 2) chk("b2b_spacing", rdy_pos[1] - rdy_pos[0], 8);
        repeat (12) @(negedge clk);
        chk("b2b_drain_idle", busy, 0);

        // Reset in the middle of an operation.
        start(12'd100, 12'd100);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_result", result, 0);
        chk("midrst_rdy", result_rdy, 0);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        bad_cycles = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (result_rdy !== 1'b0 || busy !== 1'b0) bad_cycles++;
        end
        chk("midrst_quiet", bad_cycles, 0);
        start(12'd2, 12'd3);        watch(24'h000006, "after_rst", -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
